// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory block interface.
package mem_if_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Countdown width able to hold LATENCY-1; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Load / decrement countdown used to model main-memory access latency.
module mem_latency_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load has priority; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Countdown register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block main memory answering the data cache: latched request, fixed
// latency, one-cycle DONE, saturating access counters.
module block_data_memory #(
  parameter int ADDR_WIDTH = mem_if_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = mem_if_pkg::DATA_WIDTH,
  parameter int LATENCY    = 40,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  busywait,
  output logic [CNT_WIDTH-1:0]  read_count,
  output logic [CNT_WIDTH-1:0]  write_count
);

  import mem_if_pkg::*;

  localparam int LAT_W = cnt_width(LATENCY);
  localparam logic [LAT_W-1:0] LOAD_VAL = LAT_W'(LATENCY - 1);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0] mem_array [2**ADDR_WIDTH];

  logic req;
  logic cnt_load, cnt_dec, cnt_zero;
  logic mem_wr_en;

  // Exactly one of read/write makes a legal request; both high is ignored.
  assign req = read ^ write;

  mem_latency_counter #(
    .WIDTH (LAT_W)
  ) u_latency (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (LOAD_VAL),
    .zero       (cnt_zero)
  );

  // Next-state: accept in IDLE, count down in BUSY, access on terminal count.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    readdata_d = readdata_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    mem_wr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d  = BUSY;
          op_d     = write ? OP_WRITE : OP_READ;
          addr_d   = address;
          data_d   = writedata;
          cnt_load = 1'b1;
        end
      end
      BUSY: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_d = DONE;
          if (op_q == OP_READ) begin
            readdata_d = mem_array[addr_q];
            rd_cnt_d   = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + CNT_WIDTH'(1);
          end else begin
            mem_wr_en = 1'b1;
            wr_cnt_d  = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, latched request and counters; reset aborts any pending access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      readdata_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      readdata_q <= readdata_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Storage array is never cleared by reset.
  always_ff @(posedge clock) begin
    if (mem_wr_en) begin
      mem_array[addr_q] <= data_q;
    end
  end

  assign busywait    = ((state_q == IDLE) && req) || (state_q == BUSY);
  assign readdata    = readdata_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Responder end of the cache-to-memory block interface.
- Services 32-bit block reads and writes issued by the data cache controller on its mem_read/mem_write/mem_address/mem_writedata lines.
- Models main-memory access latency with a countdown and a busywait handshake.
- Keeps saturating access counters for performance measurement.
- Sits between the data cache and the testbench/top level, one per CPU.

Parameters:
- ADDR_WIDTH, 6, block address width; depth is 2**ADDR_WIDTH blocks.
- DATA_WIDTH, 32, block width in bits.
- LATENCY, 40, clock edges from request acceptance to completion; legal range 1..255.
- CNT_WIDTH, 16, width of each access counter.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- read  in  1  block read request from the cache (mem_read).
- write  in  1  block write request from the cache (mem_write).
- address  in  ADDR_WIDTH  block address {tag,index} (mem_address).
- writedata  in  DATA_WIDTH  block to store (mem_writedata).
- readdata  out  DATA_WIDTH  block returned (mem_readdata).
- busywait  out  1  high while a request is pending (mem_busywait).
- read_count  out  CNT_WIDTH  completed reads, saturating.
- write_count  out  CNT_WIDTH  completed writes, saturating.

Behaviour:
- Reset is asynchronous and active-high, one clock. On reset: state=IDLE, counter=0, readdata=0, read_count=0, write_count=0. The storage array is not cleared.
- States are IDLE, BUSY and DONE.
- busywait is combinational: (state==IDLE && (read^write)) || state==BUSY. It is 0 in DONE and 0 in IDLE with no request.
- IDLE: at a rising edge with read^write=1, the request is accepted:
  - latch address, writedata and the operation;
  - load the countdown with LATENCY-1;
  - move to BUSY.
- BUSY:
  - input changes are ignored; the latched values are used.
  - At an edge with countdown!=0, decrement.
  - At an edge with countdown==0, perform the access and move to DONE:
    - read: readdata <= mem[latched address], read_count++;
    - write: mem[latched address] <= latched writedata, write_count++.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE at the next edge. A request still high during DONE is not accepted.
- Latency: acceptance at edge E0 gives completion at edge E0+LATENCY and busywait low during the cycle after it. The cache samples !busywait at edge E0+LATENCY+1 and memory returns to IDLE on that same edge.
- readdata holds its last value until the next completed read; writes do not change it.
- read&&write both high in IDLE is illegal: not accepted, busywait stays 0, no array change.
- Counters saturate at all ones and do not wrap.
- Reset asserted in BUSY or DONE aborts the operation; a pending write is not performed.
- Address wrap-around does not apply; every ADDR_WIDTH value is a valid block.
- Back-to-back requests: a new request is accepted at the first IDLE edge after DONE. Dirty-evict write followed by refill read therefore costs 2*(LATENCY+1) cycles of busywait gaps plus IDLE edges.

Decomposition:
- Shared package mem_if_pkg:
  - ADDR_WIDTH=6 and DATA_WIDTH=32 constants, also used by the data cache;
  - state encoding IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - op type (OP_READ, OP_WRITE).
- One sub-module, mem_latency_counter: load/decrement/zero-flag countdown of width clog2(LATENCY).
- The FSM, storage array and access counters stay in block_data_memory.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, then 0 → readdata=0, busywait=0, read_count=write_count=0. Mid-reset assertion while BUSY returns to IDLE the same instant.
- Write then read, LATENCY=4:
  - write=1, address=6'h2A, writedata=32'hDEADBEEF, held until busywait falls → busywait high for 4 edges, low at edge 5, write_count=1.
  - Then read of 6'h2A → readdata=32'hDEADBEEF exactly 4 edges after acceptance, read_count=1.
- Input stability: after acceptance of a write to 6'h05 with 32'h11223344, change address to 6'h06 and writedata to 32'h0 during BUSY → read of 6'h05 returns 32'h11223344; read of 6'h06 is unaffected.
- Illegal request: read=1 and write=1 with address 6'h01 → busywait stays 0 for 10 cycles, no counter change, later read of 6'h01 returns its prior value.
- Eviction sequence: write 6'h3F with 32'hA5A5A5A5, then read 6'h1F with no idle gap → each access completes; busywait low for exactly one cycle between them; counters 1/1.
- Saturation, with CNT_WIDTH=2: perform 5 reads → read_count=2'b11 and stays there.
